invaders_sound_ctl: RTL and testbench
=====================================

INVADERS_SOUND_CTL -- requirements
Module: invaders_sound_ctl

Interface
REQ-001 SHALL have parameter ONESHOT_CYCLES, 24'd2000000, length of each one-shot sound pulse in i_clk cycles (legal range 1..2^24-1).
REQ-002 SHALL have parameter WDOG_CYCLES, 24'd8000000, watchdog timeout in i_clk cycles (legal range 2..2^24-1).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_io_write  input  1  one-cycle CPU OUT strobe.
REQ-006 SHALL have port i_port  input  8  I/O port number, addr[7:0].
REQ-007 SHALL have port i_data  input  8  CPU OUT data.
REQ-008 SHALL have port o_amp_en  output  1  latched port 3 bit 5.
REQ-009 SHALL have port o_ufo_loop  output  1  latched port 3 bit 0 AND o_amp_en.
REQ-010 SHALL have port o_snd_active  output  9  one-shot channel busy flags: [0] shot p3b1, [1] player die p3b2, [2] invader die p3b3, [3] extra life p3b4, [4] UFO hit p5b4, [8:5] fleet step 1-4 p5b0-3.
REQ-011 SHALL have port o_wdog_rst  output  1  one-cycle watchdog expiry pulse.

Function
REQ-012 SHALL latch i_data into reg p3 when i_io_write and i_port==8'h03; into reg p5 when i_io_write and i_port==8'h05; other ports leave both unchanged.
REQ-013 SHALL make latched values visible on outputs the cycle after the write (1-cycle latency).
REQ-014 SHALL trigger a channel only on a 0->1 transition of its latched bit caused by a write; rewriting a bit already 1 SHALL NOT retrigger.
REQ-015 SHALL on trigger load the channel's 24-bit down-counter with ONESHOT_CYCLES; o_snd_active[n] SHALL be high while the counter is nonzero, i.e. exactly ONESHOT_CYCLES cycles starting the cycle after the write.
REQ-016 SHALL reload the counter to ONESHOT_CYCLES on a new trigger arriving while the channel is busy (retrigger extends the pulse).
REQ-017 SHALL count down independently of the latched bit; clearing the bit SHALL NOT end a running pulse.
REQ-018 SHALL gate every o_snd_active bit with o_amp_en; counters SHALL keep running while gated, and the output reappears if amp is re-enabled before expiry.
REQ-019 SHALL have no counter underflow: a counter at zero stays zero.
REQ-020 SHALL, with the watchdog compiled in, reload a 24-bit watchdog counter to WDOG_CYCLES on any i_io_write with i_port==8'h06, else decrement each cycle.
REQ-021 SHALL assert o_wdog_rst for exactly one cycle when the watchdog counter transitions 1->0, then reload to WDOG_CYCLES automatically.
REQ-022 SHALL give a kick write priority over expiry in the same cycle (no pulse, counter reloaded).

Reset
REQ-023 SHALL on i_rst_n low immediately clear p3, p5, all channel counters, o_snd_active, o_amp_en, o_ufo_loop, o_wdog_rst to 0 and load the watchdog counter with WDOG_CYCLES.
REQ-024 SHALL abort any running pulse on reset mid-operation; no trigger SHALL be generated by the first write after reset unless a bit goes 0->1 relative to the cleared latch.

Configuration
REQ-025 SHALL compile the watchdog (REQ-020..022) only when macro INVADERS_SOUND_WDOG_EN is defined; when undefined, o_wdog_rst SHALL be constant 0, port 8'h06 writes SHALL be ignored and no watchdog counter SHALL exist.

Verification (ONESHOT_CYCLES=10, WDOG_CYCLES=20)
REQ-026 SHALL cover: OUT 03,8'h22 at cycle N -> o_amp_en=1 and o_snd_active[0]=1 from N+1 to N+10, 0 at N+11.
REQ-027 SHALL cover: OUT 03,8'h22 then OUT 03,8'h22 at N+4 -> no retrigger, active falls at N+11; OUT 03,8'h20 then 8'h22 at N+4 -> active held until N+14.
REQ-028 SHALL cover: OUT 05,8'h0F with amp=0 -> o_snd_active[8:5]=0; OUT 03,8'h20 three cycles later -> o_snd_active[8:5]=4'hF until the counters expire.
REQ-029 SHALL cover: OUT 03,8'h21 -> o_ufo_loop=1 persistently; OUT 03,8'h00 -> o_ufo_loop=0 next cycle.
REQ-030 SHALL cover (INVADERS_SOUND_WDOG_EN): no port 6 writes -> o_wdog_rst single pulse at cycle 20 after reset release, repeating every 20; kick on expiry cycle -> no pulse.
REQ-031 SHALL cover: i_rst_n low while channels are busy -> all outputs 0 asynchronously, before the next i_clk edge.

Source files
------------

// File: rtl/invaders_sound_ctl.sv
// Space Invaders sound-port latch (ports 3/5) with nine one-shot channel timers.
// Define INVADERS_SOUND_WDOG_EN to compile in the port-6 watchdog; otherwise o_wdog_rst is tied low.
module invaders_sound_ctl #(
  parameter logic [23:0] ONESHOT_CYCLES = 24'd2000000,
  parameter logic [23:0] WDOG_CYCLES    = 24'd8000000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_io_write,
  input  logic [7:0] i_port,
  input  logic [7:0] i_data,
  output logic       o_amp_en,
  output logic       o_ufo_loop,
  output logic [8:0] o_snd_active,
  output logic       o_wdog_rst
);

  localparam int NCH = 9;

  logic [7:0]            p3, p5;
  logic [7:0]            p3_nxt, p5_nxt;
  logic [7:0]            rise3, rise5;
  logic [NCH-1:0]        trig;
  logic [NCH-1:0]        busy;
  logic [NCH-1:0][23:0]  cnt;

  always_comb begin
    p3_nxt = (i_io_write && (i_port == 8'h03)) ? i_data : p3;
    p5_nxt = (i_io_write && (i_port == 8'h05)) ? i_data : p5;
    rise3  = p3_nxt & ~p3;
    rise5  = p5_nxt & ~p5;
    // Channel order: shot, player die, invader die, extra life, UFO hit, fleet 1-4.
    trig   = {rise5[3:0], rise5[4], rise3[4:1]};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p3 <= 8'h00;
      p5 <= 8'h00;
    end else begin
      p3 <= p3_nxt;
      p5 <= p5_nxt;
    end
  end

  // Counters run regardless of the latched bit or amp gating; a retrigger reloads.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (trig[i])
          cnt[i] <= ONESHOT_CYCLES;
        else if (cnt[i] != 24'd0)
          cnt[i] <= cnt[i] - 24'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++)
      busy[i] = (cnt[i] != 24'd0);
  end

  assign o_amp_en     = p3[5];
  assign o_ufo_loop   = p3[0] & p3[5];
  assign o_snd_active = busy & {NCH{p3[5]}};

`ifdef INVADERS_SOUND_WDOG_EN
  logic [23:0] wdog_cnt;
  logic        wdog_pulse;

  // The counter never rests at zero: the 1->0 step is replaced by the auto-reload.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wdog_cnt   <= WDOG_CYCLES;
      wdog_pulse <= 1'b0;
    end else if (i_io_write && (i_port == 8'h06)) begin
      wdog_cnt   <= WDOG_CYCLES;
      wdog_pulse <= 1'b0;
    end else if (wdog_cnt == 24'd1) begin
      wdog_cnt   <= WDOG_CYCLES;
      wdog_pulse <= 1'b1;
    end else begin
      wdog_cnt   <= wdog_cnt - 24'd1;
      wdog_pulse <= 1'b0;
    end
  end

  assign o_wdog_rst = wdog_pulse;
`else
  assign o_wdog_rst = 1'b0;
`endif

endmodule

// File: tb/tb_invaders_sound_ctl.sv
// Scoreboard bench for invaders_sound_ctl (ONESHOT_CYCLES=10, WDOG_CYCLES=20).
// Watchdog expectations follow INVADERS_SOUND_WDOG_EN exactly as the design does.
module tb_invaders_sound_ctl;

  localparam logic [23:0] ONESHOT = 24'd10;
  localparam logic [23:0] WDOG    = 24'd20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       io_write = 1'b0;
  logic [7:0] port = 8'h00;
  logic [7:0] data = 8'h00;
  logic       amp_en, ufo_loop, wdog_rst;
  logic [8:0] snd_active;

  typedef struct packed {
    logic       amp;
    logic       ufo;
    logic [8:0] act;
    logic       wd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model: latch contents plus, per channel, the last cycle it is busy.
  logic [7:0] m_p3, m_p5;
  int         end_c[9];
  int         cur;
  int         wd_base;

  invaders_sound_ctl #(
    .ONESHOT_CYCLES(ONESHOT),
    .WDOG_CYCLES   (WDOG)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_io_write  (io_write),
    .i_port      (port),
    .i_data      (data),
    .o_amp_en    (amp_en),
    .o_ufo_loop  (ufo_loop),
    .o_snd_active(snd_active),
    .o_wdog_rst  (wdog_rst)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cur);
    end
  endtask

  task automatic model_reset();
    m_p3    = 8'h00;
    m_p5    = 8'h00;
    cur     = 0;
    wd_base = 0;
    for (int i = 0; i < 9; i++) end_c[i] = -1;
    sb_q.delete();
  endtask

  task automatic compare();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("amp_en",     32'(amp_en),     32'(e.amp));
      check("ufo_loop",   32'(ufo_loop),   32'(e.ufo));
      check("snd_active", 32'(snd_active), 32'(e.act));
      check("wdog_rst",   32'(wdog_rst),   32'(e.wd));
    end
  endtask

  task automatic step(input logic wr, input logic [7:0] pt, input logic [7:0] dt);
    logic [7:0] r3, r5;
    logic [8:0] tg;
    exp_t       e;
    int         nc;
    io_write = wr;
    port     = pt;
    data     = dt;
    r3 = 8'h00;
    r5 = 8'h00;
    nc = cur + 1;
    if (wr && pt == 8'h03) begin r3 = dt & ~m_p3; m_p3 = dt; end
    if (wr && pt == 8'h05) begin r5 = dt & ~m_p5; m_p5 = dt; end
    tg[0] = r3[1]; tg[1] = r3[2]; tg[2] = r3[3]; tg[3] = r3[4];
    tg[4] = r5[4];
    tg[5] = r5[0]; tg[6] = r5[1]; tg[7] = r5[2]; tg[8] = r5[3];
    e.act = '0;
    for (int i = 0; i < 9; i++) begin
      if (tg[i]) end_c[i] = cur + int'(ONESHOT);
      e.act[i] = (nc <= end_c[i]) && m_p3[5];
    end
    e.amp = m_p3[5];
    e.ufo = m_p3[0] & m_p3[5];
    e.wd  = 1'b0;
`ifdef INVADERS_SOUND_WDOG_EN
    if (wr && pt == 8'h06) begin
      wd_base = nc;
    end else if (nc == wd_base + int'(WDOG)) begin
      e.wd    = 1'b1;
      wd_base = nc;
    end
`endif
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    io_write = 1'b0;
    cur = nc;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_amp", 32'(amp_en), 32'd0);
    check("rst_ufo", 32'(ufo_loop), 32'd0);
    check("rst_act", 32'(snd_active), 32'd0);
    check("rst_wd",  32'(wdog_rst), 32'd0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [7:0] rp;
    logic [7:0] ports [6];
    ports[0] = 8'h03; ports[1] = 8'h05; ports[2] = 8'h06;
    ports[3] = 8'h07; ports[4] = 8'h03; ports[5] = 8'h05;
    model_reset();
    do_reset();

    // Single shot pulse and amp enable.
    step(1'b1, 8'h03, 8'h22);
    idle(12);

    // Rewrite of a set bit does not retrigger.
    step(1'b1, 8'h03, 8'h20);
    idle(2);
    step(1'b1, 8'h03, 8'h22);
    idle(3);
    step(1'b1, 8'h03, 8'h22);
    idle(10);

    // Clear then re-set extends the pulse.
    step(1'b1, 8'h03, 8'h20);
    step(1'b1, 8'h03, 8'h22);
    idle(1);
    step(1'b1, 8'h03, 8'h20);
    idle(1);
    step(1'b1, 8'h03, 8'h22);
    idle(12);

    // Fleet sounds gated by amp, then revealed.
    step(1'b1, 8'h03, 8'h00);
    step(1'b1, 8'h05, 8'h0F);
    idle(2);
    step(1'b1, 8'h03, 8'h20);
    idle(10);

    // UFO loop follows bit 0 and amp; writes to other ports leave latches alone.
    step(1'b1, 8'h03, 8'h21);
    step(1'b1, 8'h04, 8'hFF);
    idle(3);
    step(1'b1, 8'h03, 8'h00);
    idle(2);

    // Watchdog free-run pulses, then a kick on the expiry cycle.
    do_reset();
    idle(45);
    do_reset();
    idle(19);
    step(1'b1, 8'h06, 8'h00);
    idle(22);

    // Randomised writes across sound, watchdog and unrelated ports.
    for (int k = 0; k < 300; k++) begin
      rp = ports[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) step(1'b1, rp, 8'($urandom));
      else                           step(1'b0, 8'h00, 8'h00);
    end

    // Asynchronous reset while channels are busy.
    step(1'b1, 8'h03, 8'h3F);
    step(1'b1, 8'h05, 8'h1F);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_amp", 32'(amp_en), 32'd0);
    check("arst_ufo", 32'(ufo_loop), 32'd0);
    check("arst_act", 32'(snd_active), 32'd0);
    check("arst_wd",  32'(wdog_rst), 32'd0);
    @(negedge clk);
    do_reset();
    step(1'b1, 8'h03, 8'h20);
    idle(2);
    step(1'b1, 8'h03, 8'h3E);
    idle(12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
